// File: rtl/burv_lsu_pkg.sv
// Shared definitions for the BURV LSU request/done protocol: funct3 encodings,
// responder FSM states and the alignment/type legality check.
package burv_lsu_pkg;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

  // True when the access is illegal regardless of memory size: conflicting
  // request, misaligned half/word, unsigned store or reserved funct3.
  function automatic logic lsu_access_err(input logic       ren,
                                          input logic       wen,
                                          input logic [2:0] typ,
                                          input logic [1:0] off);
    logic err;
    err = ren & wen;
    case (typ)
      LSU_B:   ;
      LSU_H:   err = err | off[0];
      LSU_W:   err = err | (off != 2'b00);
      LSU_BU:  err = err | wen;
      LSU_HU:  err = err | wen | off[0];
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering between a 32-bit memory word and the right-aligned LSU
// data: extract/extend on the read side, mask/replicate on the write side.
module lsu_lane_align
  import burv_lsu_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [1:0]  rd_off,
  input  logic [2:0]  rd_type,
  output logic [31:0] rd_data,
  input  logic [31:0] wr_data,
  input  logic [1:0]  wr_off,
  input  logic [1:0]  wr_size,
  output logic [3:0]  wr_mask,
  output logic [31:0] wr_word
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  assign rd_byte = rd_word[8*rd_off +: 8];
  assign rd_half = rd_word[16*rd_off[1] +: 16];

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    rd_data = '0;
    case (rd_type)
      LSU_B:   rd_data = {{24{rd_byte[7]}}, rd_byte};
      LSU_BU:  rd_data = {24'h0, rd_byte};
      LSU_H:   rd_data = {{16{rd_half[15]}}, rd_half};
      LSU_HU:  rd_data = {16'h0, rd_half};
      LSU_W:   rd_data = rd_word;
      default: rd_data = '0;
    endcase
  end

  // Data is replicated across lanes so the mask alone selects what lands.
  always_comb begin
    wr_mask = 4'b1111;
    wr_word = wr_data;
    case (wr_size)
      2'b00: begin
        wr_mask = 4'b0001 << wr_off;
        wr_word = {4{wr_data[7:0]}};
      end
      2'b01: begin
        wr_mask = wr_off[1] ? 4'b1100 : 4'b0011;
        wr_word = {2{wr_data[15:0]}};
      end
      default: begin
        wr_mask = 4'b1111;
        wr_word = wr_data;
      end
    endcase
  end

endmodule

// File: rtl/lsu_mem_responder.sv
// Memory-side responder for the BURV LSU request/done protocol: captures one
// request, inserts WAIT_CYCLES wait states, then pulses lsu_done for one cycle.
module lsu_mem_responder
  import burv_lsu_pkg::*;
#(
  parameter int    SIZE_BYTES  = 1024,
  parameter int    WAIT_CYCLES = 0,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lsu_ren,
  input  logic        lsu_wen,
  input  logic [2:0]  lsu_type,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_done,
  output logic [31:0] lsu_rdata,
  output logic        lsu_err
);

  localparam int WORDS = SIZE_BYTES / 4;
  localparam int AW    = $clog2(WORDS);

  lsu_state_e  state_q, state_d;
  logic [3:0]  cnt_q;
  logic        cap_ren, cap_wen;
  logic [2:0]  cap_type;
  logic [31:0] cap_addr, cap_wdata;
  logic        acc_ren, acc_wen, acc_err;
  logic [2:0]  acc_type;
  logic [31:0] acc_addr;
  logic [31:0] rd_word, rd_ext, wr_word;
  logic [3:0]  wr_mask;
  logic        err_q, mem_we;
  logic [31:0] rdata_q;
  logic [31:0] mem [WORDS];

  // With no wait states RESP is entered on the capture edge itself, so the
  // access is evaluated from the live inputs in IDLE and the captured copy later.
  always_comb begin
    acc_ren  = cap_ren;
    acc_wen  = cap_wen;
    acc_type = cap_type;
    acc_addr = cap_addr;
    if (state_q == ST_IDLE) begin
      acc_ren  = lsu_ren;
      acc_wen  = lsu_wen;
      acc_type = lsu_type;
      acc_addr = lsu_addr;
    end
  end

  assign acc_err = lsu_access_err(acc_ren, acc_wen, acc_type, acc_addr[1:0])
                   || (acc_addr >= 32'(SIZE_BYTES));
  assign rd_word = mem[acc_addr[AW+1:2]];

  lsu_lane_align u_align (
    .rd_word (rd_word),
    .rd_off  (acc_addr[1:0]),
    .rd_type (acc_type),
    .rd_data (rd_ext),
    .wr_data (cap_wdata),
    .wr_off  (cap_addr[1:0]),
    .wr_size (cap_type[1:0]),
    .wr_mask (wr_mask),
    .wr_word (wr_word)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (lsu_ren || lsu_wen) state_d = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
      ST_WAIT: if (cnt_q == 4'(WAIT_CYCLES)) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      cap_ren   <= 1'b0;
      cap_wen   <= 1'b0;
      cap_type  <= '0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE) begin
        cnt_q <= 4'd1;
        if (lsu_ren || lsu_wen) begin
          cap_ren   <= lsu_ren;
          cap_wen   <= lsu_wen;
          cap_type  <= lsu_type;
          cap_addr  <= lsu_addr;
          cap_wdata <= lsu_wdata;
        end
      end else if (state_q == ST_WAIT) begin
        cnt_q <= cnt_q + 4'd1;
      end
      // Response registers are loaded on RESP entry and cleared on exit.
      if (state_d == ST_RESP) begin
        err_q   <= acc_err;
        rdata_q <= (acc_ren && !acc_err) ? rd_ext : '0;
      end else begin
        err_q   <= 1'b0;
        rdata_q <= '0;
      end
    end
  end

  assign lsu_done  = (state_q == ST_RESP);
  assign lsu_err   = err_q;
  assign lsu_rdata = rdata_q;

  assign mem_we = (state_q == ST_RESP) && cap_wen && !err_q;

  // NOTE: the memory array has no reset; contents survive rst_n, and a reset
  // before the RESP exit edge simply never raises mem_we.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_mask[b]) mem[cap_addr[AW+1:2]][8*b +: 8] <= wr_word[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_responder.sv
// Scoreboard bench: two responders (0 and 3 wait states) driven by randomized
// and directed LSU traffic, checked against a byte-array memory model.
module tb_lsu_mem_responder;

  localparam int SIZE = 1024;
  localparam int W0   = 0;
  localparam int W1   = 3;
  localparam int TMO  = 40;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic             clk;
  logic [1:0]       rst_n;
  logic [1:0]       ren, wen;
  logic [1:0][2:0]  typ;
  logic [1:0][31:0] addr, wdata;
  logic [1:0]       done, err;
  logic [1:0][31:0] rdata;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_on = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic [7:0] mm [2][SIZE];

  lsu_mem_responder #(.SIZE_BYTES(SIZE), .WAIT_CYCLES(W0)) dut0 (
    .clk(clk), .rst_n(rst_n[0]), .lsu_ren(ren[0]), .lsu_wen(wen[0]),
    .lsu_type(typ[0]), .lsu_addr(addr[0]), .lsu_wdata(wdata[0]),
    .lsu_done(done[0]), .lsu_rdata(rdata[0]), .lsu_err(err[0])
  );

  lsu_mem_responder #(.SIZE_BYTES(SIZE), .WAIT_CYCLES(W1)) dut1 (
    .clk(clk), .rst_n(rst_n[1]), .lsu_ren(ren[1]), .lsu_wen(wen[1]),
    .lsu_type(typ[1]), .lsu_addr(addr[1]), .lsu_wdata(wdata[1]),
    .lsu_done(done[1]), .lsu_rdata(rdata[1]), .lsu_err(err[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wc(input int d);
    return (d == 0) ? W0 : W1;
  endfunction

  task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d at cycle %0d: got %h expected %h", name, d, cyc, act, exp);
    end
  endtask

  // Reference model: little-endian byte array, rules applied directly.
  task automatic model(input int d, input bit r, input bit w, input logic [2:0] t,
                       input logic [31:0] a, input logic [31:0] wd, output exp_t e);
    int sz;
    bit ok;
    logic [31:0] v;
    sz = (t[1:0] == 2'd0) ? 1 : (t[1:0] == 2'd1) ? 2 : 4;
    ok = (r != w) && (a < SIZE) && (a % sz == 0) &&
         (t == 3'd0 || t == 3'd1 || t == 3'd2 || (r && (t == 3'd4 || t == 3'd5)));
    e.err   = !ok;
    e.rdata = '0;
    e.cyc   = 0;
    if (ok && r) begin
      v = '0;
      for (int i = 0; i < sz; i++) v = v | (32'(mm[d][a+i]) << (8*i));
      if (!t[2] && sz < 4 && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8*sz));
      e.rdata = v;
    end
    if (ok && w) begin
      for (int i = 0; i < sz; i++) mm[d][a+i] = wd[8*i +: 8];
    end
  endtask

  task automatic push(input int d, input exp_t e);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic wait_done(input int d, input bit scramble);
    bit got;
    got = 0;
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      if (done[d]) begin
        got = 1;
        break;
      end
      if (scramble) begin
        addr[d]  = $urandom;
        typ[d]   = 3'($urandom);
        wdata[d] = $urandom;
      end
    end
    if (!got) check("done_timeout", d, 32'd0, 32'd1);
  endtask

  task automatic txn(input int d, input bit r, input bit w, input logic [2:0] t,
                     input logic [31:0] a, input logic [31:0] wd, input bit scramble);
    exp_t e;
    @(negedge clk);
    model(d, r, w, t, a, wd, e);
    e.cyc = cyc + 1 + wc(d);
    push(d, e);
    ren[d] = r; wen[d] = w; typ[d] = t; addr[d] = a; wdata[d] = wd;
    wait_done(d, scramble);
    ren[d] = 1'b0;
    wen[d] = 1'b0;
  endtask

  // Read held through done: second completion follows one IDLE cycle later.
  task automatic b2b(input int d, input logic [2:0] t, input logic [31:0] a);
    exp_t e1, e2;
    @(negedge clk);
    model(d, 1'b1, 1'b0, t, a, 32'h0, e1);
    model(d, 1'b1, 1'b0, t, a, 32'h0, e2);
    e1.cyc = cyc + 1 + wc(d);
    e2.cyc = e1.cyc + 2 + wc(d);
    push(d, e1);
    push(d, e2);
    ren[d] = 1'b1; wen[d] = 1'b0; typ[d] = t; addr[d] = a;
    wait_done(d, 1'b0);
    wait_done(d, 1'b0);
    ren[d] = 1'b0;
  endtask

  task automatic mon(input int d);
    exp_t e;
    int   n;
    if (done[d]) begin
      n = (d == 0) ? q0.size() : q1.size();
      if (n == 0) begin
        check("unexpected_done", d, 32'd1, 32'd0);
      end else begin
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        check("rdata", d, rdata[d], e.rdata);
        check("err", d, 32'(err[d]), 32'(e.err));
        check("done_cycle", d, 32'(cyc), 32'(e.cyc));
      end
    end else begin
      check("idle_rdata", d, rdata[d], 32'd0);
      check("idle_err", d, 32'(err[d]), 32'd0);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      mon(0);
      mon(1);
    end
  end

  task automatic rand_txn(input int d);
    bit r, w;
    logic [2:0]  t;
    logic [31:0] a;
    int sel;
    sel = $urandom_range(0, 15);
    r = ($urandom_range(0, 1) == 1);
    w = !r;
    if (sel == 0) begin
      r = 1;
      w = 1;
    end
    t = 3'($urandom_range(0, 7));
    sel = $urandom_range(0, 7);
    if (sel < 6)       a = 32'($urandom_range(0, 63));
    else if (sel == 6) a = 32'($urandom_range(SIZE - 4, SIZE + 3));
    else               a = $urandom;
    txn(d, r, w, t, a, $urandom, 1'b1);
  endtask

  initial begin
    rst_n = 2'b11;
    ren = '0; wen = '0; typ = '0; addr = '0; wdata = '0;
    #1 rst_n = 2'b00;
    repeat (3) @(negedge clk);
    rst_n = 2'b11;
    mon_on = 1;
    for (int d = 0; d < 2; d++) begin
      check("rst_done", d, 32'(done[d]), 32'd0);
      check("rst_rdata", d, rdata[d], 32'd0);
    end

    // Known contents for every word the traffic can reach.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) txn(d, 0, 1, 3'b010, 32'(4*i), $urandom, 1'b0);
      txn(d, 0, 1, 3'b010, 32'(SIZE - 4), $urandom, 1'b0);
    end

    // Lane selection and extension on the zero-wait responder.
    txn(0, 0, 1, 3'b010, 32'd0, 32'h8899_AABB, 1'b0);
    txn(0, 1, 0, 3'b010, 32'd0, 32'h0, 1'b0);
    txn(0, 1, 0, 3'b000, 32'd1, 32'h0, 1'b0);
    txn(0, 1, 0, 3'b100, 32'd1, 32'h0, 1'b0);
    txn(0, 1, 0, 3'b001, 32'd2, 32'h0, 1'b0);
    txn(0, 1, 0, 3'b101, 32'd2, 32'h0, 1'b0);
    txn(0, 0, 1, 3'b010, 32'd4, 32'hFFFF_FFFF, 1'b0);
    txn(0, 0, 1, 3'b000, 32'd5, 32'h0000_0012, 1'b0);
    txn(0, 1, 0, 3'b010, 32'd4, 32'h0, 1'b0);
    txn(0, 0, 1, 3'b001, 32'd6, 32'h0000_3456, 1'b0);
    txn(0, 1, 0, 3'b010, 32'd4, 32'h0, 1'b0);

    // Wait states with inputs scrambled during WAIT.
    txn(1, 0, 1, 3'b010, 32'd8, 32'hCAFE_F00D, 1'b1);
    txn(1, 1, 0, 3'b010, 32'd8, 32'h0, 1'b1);

    // Error cases, each followed by a read showing memory untouched.
    for (int d = 0; d < 2; d++) begin
      txn(d, 1, 0, 3'b010, 32'd2, 32'h0, 1'b0);
      txn(d, 0, 1, 3'b001, 32'd5, 32'hDEAD_BEEF, 1'b0);
      txn(d, 1, 0, 3'b010, 32'(SIZE), 32'h0, 1'b0);
      txn(d, 1, 0, 3'b011, 32'd0, 32'h0, 1'b0);
      txn(d, 1, 1, 3'b010, 32'd0, 32'h1234_5678, 1'b0);
      txn(d, 0, 1, 3'b100, 32'd0, 32'h5555_5555, 1'b0);
      txn(d, 0, 1, 3'b010, 32'd2, 32'h6666_6666, 1'b0);
      txn(d, 1, 0, 3'b010, 32'd0, 32'h0, 1'b0);
      txn(d, 1, 0, 3'b010, 32'd4, 32'h0, 1'b0);
      b2b(d, 3'b010, 32'd8);
    end

    // Reset during WAIT discards the pending store.
    @(negedge clk);
    ren[1] = 1'b0; wen[1] = 1'b1; typ[1] = 3'b010; addr[1] = 32'd12; wdata[1] = 32'hA5A5_0F0F;
    repeat (2) @(negedge clk);
    rst_n[1] = 1'b0;
    #3;
    rst_n[1] = 1'b1;
    wen[1] = 1'b0;
    repeat (6) @(negedge clk);
    txn(1, 1, 0, 3'b010, 32'd12, 32'h0, 1'b0);

    for (int i = 0; i < 150; i++) begin
      rand_txn(0);
      rand_txn(1);
    end

    repeat (8) @(negedge clk);
    check("q0_drained", 0, 32'(q0.size()), 32'd0);
    check("q1_drained", 1, 32'(q1.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
